fc_layer_tdm: RTL and testbench
===============================

Name: fc_layer_tdm

Overview:
- Fully-connected NN layer that time-multiplexes NUM_NEURON neurons onto NUM_LANE physical MAC lanes.
- Replaces the one-neuron-instance-per-output layer style, and adds:
  - an input frame buffer,
  - external weight/bias memory,
  - fixed-point rounding and saturation with selectable activation,
  - a serial valid/ready output stream that feeds the next layer directly.

Parameters:
- NUM_NEURON, 10, neurons (outputs) in the layer; must be a multiple of NUM_LANE.
- NUM_INPUT, 784, input samples per frame.
- DATA_WIDTH, 16, signed two's-complement width of x, w, bias and y.
- FRAC_BITS, 8, fractional bits of the Q format shared by x, w, bias and y.
- NUM_LANE, 2, neurons computed concurrently. G = NUM_NEURON/NUM_LANE groups.
- ACT_MODE, 0, activation: 0 = identity, 1 = ReLU.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- x_valid, in, 1, input sample strobe.
- x_in, in, DATA_WIDTH, input sample.
- x_ready, out, 1, layer is accepting input samples.
- w_rd_en, out, 1, weight memory read enable.
- w_addr, out, clog2(G*(NUM_INPUT+1)), read address = g*(NUM_INPUT+1)+k. k = NUM_INPUT selects the bias word.
- w_data, in, NUM_LANE*DATA_WIDTH, lane l in bits [l*DATA_WIDTH +: DATA_WIDTH]; returned 1 cycle after w_rd_en.
- y_valid, out, 1, output sample valid.
- y_data, out, DATA_WIDTH, output sample; neuron order 0..NUM_NEURON-1.
- y_last, out, 1, marks neuron NUM_NEURON-1.
- y_ready, in, 1, downstream accepts.
- busy, out, 1, high in COMPUTE or DRAIN.

Behaviour:
- Single clock clk; reset rst is asynchronous and active-high.
- Reset values: state = LOAD, all counters = 0; x_ready = 1; w_rd_en, y_valid, y_last, busy = 0; w_addr, y_data = 0.
- A reset asserted in any state aborts the frame immediately. Buffers are not cleared, but their contents are never output.
- State LOAD (x_ready = 1):
  - Each cycle with x_valid = 1 stores x_in at buf[in_cnt] and increments in_cnt.
  - On acceptance of sample NUM_INPUT-1, go to COMPUTE next cycle and clear in_cnt.
- State COMPUTE (x_ready = 0; x_valid is ignored and samples are dropped):
  - Each group g takes exactly NUM_INPUT+3 cycles.
  - Cycles 0..NUM_INPUT: w_rd_en = 1, w_addr = g*(NUM_INPUT+1)+cycle.
  - Cycles 1..NUM_INPUT: each lane performs acc_l += x[k]*w_l, where k = cycle-1. Products are full 2*DATA_WIDTH signed.
  - Cycle NUM_INPUT+1: acc_l += bias_l <<< FRAC_BITS.
  - Cycle NUM_INPUT+2: lane l result goes to obuf[g*NUM_LANE+l]; accumulators clear.
  - After the last group, go to DRAIN.
  - Total COMPUTE duration = G*(NUM_INPUT+3) cycles.
- Accumulator width = 2*DATA_WIDTH + clog2(NUM_INPUT+1); it never wraps.
- Result calculation:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half up.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If ACT_MODE = 1 and r < 0, then r = 0.
- State DRAIN:
  - y_valid = 1 and y_data = obuf[out_cnt]; y_last = 1 when out_cnt = NUM_NEURON-1.
  - Transfer on y_valid & y_ready.
  - y_data and y_last are held stable while y_ready = 0.
  - After the transfer with y_last, go to LOAD next cycle: y_valid = 0, x_ready = 1.
- busy = 1 exactly in COMPUTE and DRAIN.
- No frame overlap: the next frame's inputs are accepted only after the drain completes.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs reach their reset values without a clock edge; x_ready = 1 after deassert.
- Basic frame (NUM_INPUT=4, NUM_NEURON=4, NUM_LANE=2, FRAC_BITS=8), all x = 0x0100, all w = 0x0080, bias = 0x0040:
  - Expect 4 outputs of 0x0240; y_last on the 4th.
  - First y_valid exactly 14 cycles after COMPUTE entry; the w_addr sequence is 0..9.
- Saturation, same parameters:
  - x = 0x7FFF with w = 0x7FFF -> 0x7FFF.
  - x = 0x7FFF with w = 0x8000 -> 0x8000 (ACT_MODE=0), and 0x0000 (ACT_MODE=1).
- Backpressure: hold y_ready = 0 for 5 cycles on the 2nd output -> y_data stable; all 4 outputs delivered in order with none lost; x_ready stays 0 until after y_last transfers.
- Dropped input: toggle x_valid with x_in = 0x7FFF throughout COMPUTE -> results identical to the basic frame.
- Reset mid-COMPUTE (group 1): busy = 0 and no y_valid; next full frame produces correct values.

Source files
------------

// File: rtl/fc_layer_tdm.sv
// fc_layer_tdm: fully-connected layer, NUM_NEURON neurons time-multiplexed onto NUM_LANE MAC lanes,
// with input frame buffer, external weight/bias memory, round/saturate/activation and a serial output stream.
module fc_layer_tdm #(
  parameter int NUM_NEURON = 10,
  parameter int NUM_INPUT  = 784,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_LANE   = 2,
  parameter int ACT_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             x_valid,
  input  logic [DATA_WIDTH-1:0]            x_in,
  output logic                             x_ready,
  output logic                             w_rd_en,
  output logic [$clog2(NUM_NEURON/NUM_LANE*(NUM_INPUT+1))-1:0] w_addr,
  input  logic [NUM_LANE*DATA_WIDTH-1:0]   w_data,
  output logic                             y_valid,
  output logic [DATA_WIDTH-1:0]            y_data,
  output logic                             y_last,
  input  logic                             y_ready,
  output logic                             busy
);
  localparam int G   = NUM_NEURON / NUM_LANE;
  localparam int AW  = $clog2(G * (NUM_INPUT + 1));
  localparam int ACW = 2 * DATA_WIDTH + $clog2(NUM_INPUT + 1);
  localparam int IW  = NUM_INPUT > 1 ? $clog2(NUM_INPUT) : 1;
  localparam int CW  = $clog2(NUM_INPUT + 3);
  localparam int GW  = G > 1 ? $clog2(G) : 1;
  localparam int OW  = NUM_NEURON > 1 ? $clog2(NUM_NEURON) : 1;
  localparam logic [1:0] LOAD = 2'd0, COMPUTE = 2'd1, DRAIN = 2'd2;
  localparam logic [CW-1:0] C_NI = CW'(NUM_INPUT), C_BIAS = CW'(NUM_INPUT + 1), C_LAST = CW'(NUM_INPUT + 2);
  localparam logic signed [ACW-1:0] HALF = ACW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACW-1:0] MAXV = ACW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACW-1:0] MINV = -MAXV - ACW'(1);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic signed [ACW-1:0]          acc_q [NUM_LANE];
  logic signed [ACW-1:0]          acc_d [NUM_LANE];
  logic signed [ACW-1:0]          rnd   [NUM_LANE];
  logic signed [DATA_WIDTH-1:0]   res   [NUM_LANE];
  logic signed [DATA_WIDTH-1:0]   w_lane [NUM_LANE];
  logic signed [2*DATA_WIDTH-1:0] prod  [NUM_LANE];
  logic signed [DATA_WIDTH-1:0]   xbuf  [NUM_INPUT];
  logic signed [DATA_WIDTH-1:0]   obuf  [NUM_NEURON];
  logic signed [DATA_WIDTH-1:0]   xk;
  logic rd_phase, mac_phase, bias_phase, grp_done;

  assign x_ready    = state_q == LOAD;
  assign busy       = state_q != LOAD;
  assign rd_phase   = state_q == COMPUTE && cyc_q <= C_NI;
  assign mac_phase  = state_q == COMPUTE && cyc_q != '0 && cyc_q <= C_NI;
  assign bias_phase = state_q == COMPUTE && cyc_q == C_BIAS;
  assign grp_done   = state_q == COMPUTE && cyc_q == C_LAST;
  assign w_rd_en    = rd_phase;
  assign w_addr     = rd_phase ? addr_q : '0;
  assign y_valid    = state_q == DRAIN;
  assign y_data     = y_valid ? obuf[out_cnt_q] : '0;
  assign y_last     = y_valid && out_cnt_q == OW'(NUM_NEURON - 1);
  assign xk         = mac_phase ? xbuf[IW'(cyc_q - CW'(1))] : '0;

  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      w_lane[l] = w_data[l*DATA_WIDTH +: DATA_WIDTH];
      prod[l]   = xk * w_lane[l];
      acc_d[l]  = grp_done ? '0 : mac_phase ? acc_q[l] + ACW'(prod[l]) :
                  bias_phase ? acc_q[l] + (ACW'(w_lane[l]) <<< FRAC_BITS) : acc_q[l];
      rnd[l]    = (acc_q[l] + HALF) >>> FRAC_BITS;
      res[l]    = (ACT_MODE == 1 && rnd[l] < 0) ? '0 : rnd[l] > MAXV ? DATA_WIDTH'(MAXV) :
                  rnd[l] < MINV ? DATA_WIDTH'(MINV) : DATA_WIDTH'(rnd[l]);
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    cyc_d     = cyc_q;
    grp_d     = grp_q;
    out_cnt_d = out_cnt_q;
    addr_d    = rd_phase ? addr_q + AW'(1) : addr_q;
    if (state_q == LOAD && x_valid) begin
      in_cnt_d = in_cnt_q == IW'(NUM_INPUT - 1) ? '0 : in_cnt_q + IW'(1);
      state_d  = in_cnt_q == IW'(NUM_INPUT - 1) ? COMPUTE : LOAD;
    end
    if (state_q == COMPUTE) cyc_d = grp_done ? '0 : cyc_q + CW'(1);
    if (grp_done) begin
      grp_d = grp_q == GW'(G - 1) ? '0 : grp_q + GW'(1);
      addr_d = grp_q == GW'(G - 1) ? '0 : addr_q;
      state_d = grp_q == GW'(G - 1) ? DRAIN : COMPUTE;
    end
    if (y_valid && y_ready) begin
      out_cnt_d = y_last ? '0 : out_cnt_q + OW'(1);
      state_d   = y_last ? LOAD : DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      cyc_q     <= '0;
      grp_q     <= '0;
      out_cnt_q <= '0;
      addr_q    <= '0;
      for (int l = 0; l < NUM_LANE; l++) acc_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      cyc_q     <= cyc_d;
      grp_q     <= grp_d;
      out_cnt_q <= out_cnt_d;
      addr_q    <= addr_d;
      for (int l = 0; l < NUM_LANE; l++) acc_q[l] <= acc_d[l];
    end
  end

  // Frame buffers are never cleared; each frame fully rewrites obuf before it is drained.
  always_ff @(posedge clk) begin
    if (x_ready && x_valid) xbuf[in_cnt_q] <= x_in;
    if (grp_done)
      for (int l = 0; l < NUM_LANE; l++) obuf[OW'(int'(grp_q) * NUM_LANE + l)] <= res[l];
  end
endmodule

// File: tb/tb_fc_layer_tdm.sv
// tb_fc_layer_tdm: directed frame vectors on a 4-input, 4-neuron, 2-lane layer in identity and ReLU variants.
module tb_fc_layer_tdm;
  logic clk = 0, rst = 1, x_valid = 0, y_ready = 1;
  logic [15:0] x_in = '0;
  logic w_rd_en, w_rd_en_r, x_ready, x_ready_r, y_valid, y_valid_r, y_last, y_last_r, busy, busy_r;
  logic [3:0] w_addr, w_addr_r;
  logic [31:0] w_data = '0, w_data_r = '0;
  logic [15:0] y_data, y_data_r;
  logic [31:0] mem [10];
  logic [3:0] addrq [$];
  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic [0:3][15:0] x, w, b, e0, e1;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  fc_layer_tdm #(.NUM_NEURON(4), .NUM_INPUT(4), .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_LANE(2), .ACT_MODE(0)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready), .w_rd_en(w_rd_en),
    .w_addr(w_addr), .w_data(w_data), .y_valid(y_valid), .y_data(y_data), .y_last(y_last),
    .y_ready(y_ready), .busy(busy));

  fc_layer_tdm #(.NUM_NEURON(4), .NUM_INPUT(4), .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_LANE(2), .ACT_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready_r), .w_rd_en(w_rd_en_r),
    .w_addr(w_addr_r), .w_data(w_data_r), .y_valid(y_valid_r), .y_data(y_data_r), .y_last(y_last_r),
    .y_ready(y_ready), .busy(busy_r));

  always @(posedge clk) begin
    if (w_rd_en) w_data <= mem[w_addr];
    if (w_rd_en_r) w_data_r <= mem[w_addr_r];
  end

  always @(negedge clk) if (w_rd_en) addrq.push_back(w_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_x_ready"}, x_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_y_last"}, y_last, 0);
    chk({tag, "_w_rd_en"}, w_rd_en, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_y_data"}, y_data, 0);
    chk({tag, "_busy_r"}, busy_r, 0);
    chk({tag, "_y_valid_r"}, y_valid_r, 0);
  endtask

  task automatic feed(input vec_t v);
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 5; k++)
        for (int l = 0; l < 2; l++)
          mem[g*5+k][l*16 +: 16] = (k == 4) ? v.b[g*2+l] : v.w[g*2+l];
    addrq.delete();
    chk("feed_x_ready", x_ready, 1);
    for (int k = 0; k < 4; k++) begin
      x_valid = 1;
      x_in = v.x[k];
      @(negedge clk);
    end
    x_valid = 0;
  endtask

  task automatic run_frame(input vec_t v, input bit bp, input bit drop, input bit chk_addr);
    int n;
    feed(v);
    chk("busy_compute", busy, 1);
    n = 0;
    while (!y_valid && n < 100) begin
      if (drop) begin
        x_valid = ~x_valid;
        x_in = 16'h7FFF;
      end
      @(negedge clk);
      n++;
    end
    x_valid = 0;
    chk("latency", n, 14);
    if (chk_addr) begin
      chk("addr_count", addrq.size(), 10);
      for (int j = 0; j < addrq.size(); j++) chk($sformatf("w_addr[%0d]", j), addrq[j], j);
    end
    for (int o = 0; o < 4; o++) begin
      n = 0;
      while (!y_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("y_valid", y_valid, 1);
      chk($sformatf("y_data[%0d]", o), y_data, v.e0[o]);
      chk($sformatf("y_data_relu[%0d]", o), y_data_r, v.e1[o]);
      chk($sformatf("y_last[%0d]", o), y_last, o == 3);
      chk("x_ready_drain", x_ready, 0);
      if (bp && o == 1) begin
        y_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold", y_data, v.e0[o]);
          chk("bp_valid", y_valid, 1);
          chk("bp_x_ready", x_ready, 0);
        end
        y_ready = 1;
      end
      @(negedge clk);
    end
    chk("done_x_ready", x_ready, 1);
    chk("done_y_valid", y_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    int n, seen;
    vecs[0] = '{x: {4{16'h0100}}, w: {4{16'h0080}}, b: {4{16'h0040}}, e0: {4{16'h0240}}, e1: {4{16'h0240}}};
    vecs[1] = '{x: {4{16'h7FFF}}, w: {4{16'h7FFF}}, b: {4{16'h0040}}, e0: {4{16'h7FFF}}, e1: {4{16'h7FFF}}};
    vecs[2] = '{x: {4{16'h7FFF}}, w: {4{16'h8000}}, b: {4{16'h0040}}, e0: {4{16'h8000}}, e1: {4{16'h0000}}};
    vecs[3] = '{x: {16'h0100, 16'h0200, 16'hFF00, 16'h0080}, w: {16'h0040, 16'h0080, 16'h00C0, 16'h0100},
                b: {4{16'h0000}}, e0: {16'h00A0, 16'h0140, 16'h01E0, 16'h0280},
                e1: {16'h00A0, 16'h0140, 16'h01E0, 16'h0280}};
    vecs[4] = '{x: {16'h0080, 16'h0000, 16'h0000, 16'h0000}, w: {16'h0001, 16'hFFFF, 16'hFFFE, 16'h0000},
                b: {16'h0000, 16'h0000, 16'h0000, 16'h0003}, e0: {16'h0001, 16'h0000, 16'hFFFF, 16'h0003},
                e1: {16'h0001, 16'h0000, 16'h0000, 16'h0003}};
    vecs[5] = vecs[0];
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_frame(vecs[i], i == 3, i == 5, i == 0);

    feed(vecs[0]);
    n = 0;
    while (!y_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_y_valid", y_valid, 1);
    @(negedge clk);
    #2 rst = 1;
    #1 check_idle("rst_drain");
    @(negedge clk);
    rst = 0;

    feed(vecs[3]);
    repeat (9) @(negedge clk);
    chk("g1_busy", busy, 1);
    chk("g1_w_addr", w_addr, 7);
    #2 rst = 1;
    #1 chk("rst_g1_busy", busy, 0);
    chk("rst_g1_y_valid", y_valid, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (y_valid || busy) seen++;
    end
    chk("rst_g1_quiet", seen, 0);
    run_frame(vecs[3], 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
